// File: rtl/arith_pkg.sv
// Shared definitions for the sequential arithmetic blocks (multiplier, divider).
package arith_pkg;

  // Handshake state sequence common to all start/done arithmetic blocks.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arith_state_e;

  // A product of two W-bit operands needs twice the operand width.
  localparam int ARITH_RESULT_SCALE = 2;

  // Result/accumulator width for a given operand width.
  function automatic int arith_result_width(input int width);
    return ARITH_RESULT_SCALE * width;
  endfunction

endpackage

// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add multiply-accumulate: o_result = A * B + C.
// One multiplier bit is consumed per BUSY cycle, LSB first; the addend is
// preloaded into the accumulator so no extra add step is needed at the end.
module shift_add_multiplier
  import arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic                                  i_start,
  input  logic [WIDTH-1:0]                      i_multiplicand,
  input  logic [WIDTH-1:0]                      i_multiplier,
  input  logic [WIDTH-1:0]                      i_addend,
  output logic                                  o_busy,
  output logic                                  o_done,
  output logic [arith_result_width(WIDTH)-1:0]  o_result
);

  localparam int RW = arith_result_width(WIDTH);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  arith_state_e    r_state;
  logic [RW-1:0]   r_acc;
  logic [RW-1:0]   r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [CW-1:0]   r_count;
  logic            r_busy;
  logic            r_done;
  logic [RW-1:0]   r_result;

  arith_state_e    w_state_nxt;
  logic [RW-1:0]   w_acc_nxt;
  logic [RW-1:0]   w_mcand_nxt;
  logic [WIDTH-1:0] w_mplier_nxt;
  logic [CW-1:0]   w_count_nxt;
  logic            w_busy_nxt;
  logic            w_done_nxt;
  logic [RW-1:0]   w_result_nxt;
  logic [RW-1:0]   w_partial;
  logic [RW-1:0]   w_acc_sum;

  // Partial product for the current multiplier bit and the accumulator update.
  always_comb begin
    w_partial = '0;
    if (r_mplier[0]) begin
      w_partial = r_mcand;
    end else begin
      w_partial = '0;
    end
    w_acc_sum = r_acc + w_partial;
  end

  // FSM and datapath next-state; o_result is only rewritten on the final BUSY edge.
  always_comb begin
    w_state_nxt  = r_state;
    w_acc_nxt    = r_acc;
    w_mcand_nxt  = r_mcand;
    w_mplier_nxt = r_mplier;
    w_count_nxt  = r_count;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_result_nxt = r_result;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_acc_nxt    = {{WIDTH{1'b0}}, i_addend};
          w_mcand_nxt  = {{WIDTH{1'b0}}, i_multiplicand};
          w_mplier_nxt = i_multiplier;
          w_count_nxt  = '0;
          w_busy_nxt   = 1'b1;
          w_state_nxt  = ST_BUSY;
        end else begin
          w_busy_nxt   = 1'b0;
          w_state_nxt  = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // Always run the full WIDTH iterations so latency is data-independent.
        w_acc_nxt    = w_acc_sum;
        w_mcand_nxt  = {r_mcand[RW-2:0], 1'b0};
        w_mplier_nxt = {1'b0, r_mplier[WIDTH-1:1]};
        w_count_nxt  = r_count + {{(CW-1){1'b0}}, 1'b1};
        if (r_count == LAST_COUNT) begin
          w_result_nxt = w_acc_sum;
          w_done_nxt   = 1'b1;
          w_state_nxt  = ST_DONE;
        end else begin
          w_state_nxt  = ST_BUSY;
        end
      end
      ST_DONE: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything including the result.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_acc    <= w_acc_nxt;
      r_mcand  <= w_mcand_nxt;
      r_mplier <= w_mplier_nxt;
      r_count  <= w_count_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_result <= w_result_nxt;
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_result = r_result;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier (WIDTH=4).
module tb_shift_add_multiplier;

  logic       i_clk;
  logic       i_rst;
  logic       i_start;
  logic [3:0] i_multiplicand;
  logic [3:0] i_multiplier;
  logic [3:0] i_addend;
  logic       o_busy;
  logic       o_done;
  logic [7:0] o_result;

  int n_checks;
  int n_errors;
  int prev_result;

  typedef struct {
    int a;
    int b;
    int c;
    int exp;
  } vec_t;

  vec_t vecs[8];

  shift_add_multiplier #(.WIDTH(4)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_start        (i_start),
    .i_multiplicand (i_multiplicand),
    .i_multiplier   (i_multiplier),
    .i_addend       (i_addend),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_result       (o_result)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference: result is plain A*B+C, done in cycle 5, busy in cycles 1..5.
  // Called at a negedge in IDLE (cycle 0); returns at the negedge of cycle 6.
  task automatic run_trace(input int a, input int b, input int c, input bit noise);
    int exp_v;
    exp_v = a * b + c;
    i_multiplicand = 4'(a);
    i_multiplier   = 4'(b);
    i_addend       = 4'(c);
    i_start        = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge i_clk);
      check($sformatf("busy c%0d A%0d B%0d C%0d", k, a, b, c), 32'(o_busy), 32'(k <= 5));
      check($sformatf("done c%0d A%0d B%0d C%0d", k, a, b, c), 32'(o_done), 32'(k == 5));
      check($sformatf("result c%0d A%0d B%0d C%0d", k, a, b, c), 32'(o_result),
            (k >= 5) ? 32'(exp_v) : 32'(prev_result));
      i_multiplicand = 4'($urandom);
      i_multiplier   = 4'($urandom);
      i_addend       = 4'($urandom);
      if (noise && k < 5) i_start = 1'($urandom_range(0, 1));
      else                i_start = 1'b0;
    end
    prev_result = exp_v;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    prev_result = 0;
    i_rst = 1'b1;
    i_start = 1'b0;
    i_multiplicand = 4'd0;
    i_multiplier = 4'd0;
    i_addend = 4'd0;

    vecs[0] = '{a: 3,  b: 5,  c: 2,  exp: 17};
    vecs[1] = '{a: 15, b: 15, c: 15, exp: 240};
    vecs[2] = '{a: 0,  b: 9,  c: 7,  exp: 7};
    vecs[3] = '{a: 4,  b: 4,  c: 0,  exp: 16};
    vecs[4] = '{a: 15, b: 0,  c: 15, exp: 15};
    vecs[5] = '{a: 1,  b: 1,  c: 0,  exp: 1};
    vecs[6] = '{a: 8,  b: 8,  c: 1,  exp: 65};
    vecs[7] = '{a: 7,  b: 11, c: 0,  exp: 77};

    // Reset state
    repeat (2) @(negedge i_clk);
    check("rst busy", 32'(o_busy), 32'd0);
    check("rst done", 32'(o_done), 32'd0);
    check("rst result", 32'(o_result), 32'd0);
    i_rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge i_clk);
      check($sformatf("idle done c%0d", k), 32'(o_done), 32'd0);
      check($sformatf("idle busy c%0d", k), 32'(o_busy), 32'd0);
    end
    check("idle result", 32'(o_result), 32'd0);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      check($sformatf("table model %0d", i), 32'(vecs[i].a * vecs[i].b + vecs[i].c), 32'(vecs[i].exp));
      run_trace(vecs[i].a, vecs[i].b, vecs[i].c, 1'b0);
      check($sformatf("table result %0d", i), 32'(o_result), 32'(vecs[i].exp));
    end

    // Start held high; operands change in cycle 2 (A=5,B=6,C=3 -> 33)
    i_multiplicand = 4'd2;
    i_multiplier   = 4'd3;
    i_addend       = 4'd1;
    i_start        = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge i_clk);
      check($sformatf("held busy c%0d", k), 32'(o_busy), 32'((k >= 1 && k <= 5) || (k >= 7 && k <= 11)));
      check($sformatf("held done c%0d", k), 32'(o_done), 32'(k == 5 || k == 11));
      if (k >= 5 && k <= 10) check($sformatf("held result1 c%0d", k), 32'(o_result), 32'd7);
      else if (k >= 11)      check($sformatf("held result2 c%0d", k), 32'(o_result), 32'd33);
      else                   check($sformatf("held prev c%0d", k), 32'(o_result), 32'(prev_result));
      if (k == 2) begin
        i_multiplicand = 4'd5;
        i_multiplier   = 4'd6;
        i_addend       = 4'd3;
      end
      if (k == 11) i_start = 1'b0;
    end
    prev_result = 33;

    // Asynchronous reset in cycle 3 of an operation
    i_multiplicand = 4'd9;
    i_multiplier   = 4'd9;
    i_addend       = 4'd9;
    i_start        = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (2) @(negedge i_clk);
    #2 i_rst = 1'b1;
    #1;
    check("abort busy", 32'(o_busy), 32'd0);
    check("abort done", 32'(o_done), 32'd0);
    check("abort result", 32'(o_result), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    prev_result = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge i_clk);
      check($sformatf("post-abort done c%0d", k), 32'(o_done), 32'd0);
      check($sformatf("post-abort busy c%0d", k), 32'(o_busy), 32'd0);
      check($sformatf("post-abort result c%0d", k), 32'(o_result), 32'd0);
    end
    run_trace(4, 4, 0, 1'b0);
    check("after abort 4*4+0", 32'(o_result), 32'd16);

    // Exhaustive sweep, with start noise while busy on alternate operations
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 16; c++) begin
          run_trace(a, b, c, 1'(c & 1));
        end
      end
    end

    // Random operands with random idle gaps between operations
    for (int n = 0; n < 200; n++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        @(negedge i_clk);
        check($sformatf("gap done op%0d", n), 32'(o_done), 32'd0);
        check($sformatf("gap result op%0d", n), 32'(o_result), 32'(prev_result));
      end
      run_trace(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 15)), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
- Sequential shift-and-add multiply-accumulate unit: computes o_result = i_multiplicand * i_multiplier + i_addend over WIDTH iterations.
- Inverse companion to the sequential division datapath. It rebuilds a dividend from divisor, quotient and remainder, and also serves as a general small-width multiplier.
- Uses the same start/done handshake as the other sequential arithmetic blocks.

Parameters:
- WIDTH, 4, operand width in bits. Legal range 2..16. The result is 2*WIDTH bits.

Ports:
- i_clk  input  1  clock, all logic on rising edge
- i_rst  input  1  asynchronous active-high reset
- i_start  input  1  request; sampled only in IDLE
- i_multiplicand  input  WIDTH  operand A, e.g. divisor
- i_multiplier  input  WIDTH  operand B, e.g. quotient; scanned LSB first
- i_addend  input  WIDTH  value preloaded into the accumulator, e.g. remainder
- o_busy  output  1  high while in BUSY or DONE
- o_done  output  1  single-cycle completion pulse
- o_result  output  2*WIDTH  final A*B+C; held until the next accepted start

Behaviour:
- Reset (async assert, sync deassert by the environment): state=IDLE, o_busy=0, o_done=0, o_result=0, internal accumulator, shift registers and counter cleared.
- All outputs are registered. No combinational path from inputs to outputs.
- States are IDLE, BUSY and DONE.
- IDLE:
  - On i_start=1, latch operands at the clock edge:
    - acc = zero-extended i_addend
    - mcand = zero-extended i_multiplicand
    - mplier = i_multiplier
    - count = 0
  - Go to BUSY.
- BUSY, on each edge:
  - If mplier[0], acc += mcand (2*WIDTH-bit add).
  - mcand <<= 1, mplier >>= 1, count++.
  - When count==WIDTH-1 on this edge: write the final acc into o_result and go to DONE.
- DONE: o_done=1 for exactly this one cycle, then return to IDLE unconditionally.
- Latency: exactly WIDTH BUSY cycles and one DONE cycle. No early termination, even if mplier becomes 0.
  - With the start edge at cycle 0, o_done is high during cycle WIDTH+1, and o_result is valid in that same cycle.
- Width/overflow: max result is (2^W-1)^2+(2^W-1) = 2^(2W)-2^W < 2^(2W). No overflow is possible and no carry-out is exposed.
- i_start while BUSY or DONE is ignored. Operands are not re-sampled and the result is unaffected.
  - Back-to-back operation: raise start in the cycle after o_done; it is accepted in IDLE.
- Input changes after acceptance have no effect, because operands are latched.
- o_result keeps its previous value during IDLE and BUSY. It changes only on the final BUSY edge.
- Reset mid-operation: immediate return to IDLE with all outputs 0. No o_done is produced for the aborted operation.
- Zero operands need no special handling: A=0 or B=0 gives o_result = i_addend.

Decomposition:
- Shared package arith_pkg holds:
  - a state enum typedef (IDLE, BUSY, DONE), also usable by other sequential arithmetic blocks
  - a localparam helper for result width (2*WIDTH)
- Counter width is $clog2(WIDTH)+1.
- No sub-module. Datapath (accumulator, shift registers, adder) and FSM live in one module of about 150 lines.

Test Plan:
- WIDTH=4; reset then idle: o_busy=0, o_done=0, o_result=8'h00. Start is never raised, so o_done stays 0 for 20 cycles.
- A=3, B=5, C=2, start pulse at cycle 0 -> o_done high only in cycle 5, o_result=8'd17 (0x11), o_busy high cycles 1-5.
- A=15, B=15, C=15 -> o_result=8'd240 (0xF0), with no overflow. Then A=0, B=9, C=7 -> o_result=8'd7.
- Start held high continuously from cycle 0 with A=2, B=3, C=1 and operands changed in cycle 2:
  - first result is 8'd7, with o_done in cycle 5
  - next acceptance happens in cycle 6 (IDLE), using the new operands
- Reset asserted asynchronously in cycle 3 of an operation -> outputs 0 immediately, no o_done follows. The next operation A=4, B=4, C=0 yields 8'd16.
- Exhaustive sweep of all A,B,C in 0..15 -> every o_result equals A*B+C, and each o_done arrives exactly 5 cycles after acceptance.
